// File: rtl/mem_bus.sv
// Memory-access pipeline stage: passes ALU results through, or runs one
// req/ack bus transaction per load/store with big-endian lanes and extension.
module mem_bus (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        align_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, is_mem;
    logic        sz_byte, sz_half, sz_word, sign_ext;
    logic        misalign, access_ok;
    logic [3:0]  lane_sel;
    logic [31:0] store_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        sign_ext = 1'b0;
        case (mem_op_i)
            4'd1: begin is_load = 1'b1;  sz_byte = 1'b1; sign_ext = 1'b1; end
            4'd2: begin is_load = 1'b1;  sz_byte = 1'b1; end
            4'd3: begin is_load = 1'b1;  sz_half = 1'b1; sign_ext = 1'b1; end
            4'd4: begin is_load = 1'b1;  sz_half = 1'b1; end
            4'd5: begin is_load = 1'b1;  sz_word = 1'b1; end
            4'd6: begin is_store = 1'b1; sz_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; sz_half = 1'b1; end
            4'd8: begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem    = is_load | is_store;
    assign misalign  = (sz_half & mem_addr_i[0]) | (sz_word & (mem_addr_i[1:0] != 2'b00));
    assign access_ok = is_mem & ~misalign;

    // Big-endian lanes: byte offset 0 lives in bits 31:24 (sel bit 3).
    always_comb begin
        lane_sel   = 4'b0000;
        store_data = mem_sdata_i;
        if (sz_byte) begin
            lane_sel   = 4'b1000 >> mem_addr_i[1:0];
            store_data = {4{mem_sdata_i[7:0]}};
        end else if (sz_half) begin
            lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            store_data = {2{mem_sdata_i[15:0]}};
        end else if (sz_word) begin
            lane_sel   = 4'b1111;
        end
    end

    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
        if (sz_byte)
            load_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
        else if (sz_half)
            load_val = {{16{sign_ext & ld_half[15]}}, ld_half};
        else
            load_val = rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            sel_q    <= 4'd0;
            bwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        bwdata_d = bwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: if (access_ok) begin
                state_d  = BUSY;
                req_d    = 1'b1;
                we_d     = is_store;
                addr_d   = {mem_addr_i[31:2], 2'b00};
                sel_d    = lane_sel;
                bwdata_d = store_data;
            end
            BUSY: if (bus_ack_i) begin
                state_d = DONE;
                req_d   = 1'b0;
                rdata_d = bus_rdata_i;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result path is combinational so non-memory ops cost no stall cycle.
    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        if (!rst) begin
            wd_o    = wd_i;
            wdata_o = wdata_i;
            case (state_q)
                IDLE: begin
                    if (!is_mem)
                        wreg_o = wreg_i;
                    else if (misalign)
                        align_err_o = 1'b1;
                    else
                        stallreq_o = 1'b1;
                end
                BUSY: stallreq_o = 1'b1;
                DONE: if (is_load) begin
                    wreg_o  = wreg_i;
                    wdata_o = load_val;
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = bwdata_q;

endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: combinational vector table plus scoreboarded bus
// transactions, reset-in-BUSY and back-to-back sequences.
module tb_mem_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        align_err_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    mem_bus dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .align_err_o(align_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        exp_wreg;
        logic        exp_align;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle (C0), returns sampled inside the DONE cycle.
    task automatic access(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int k,
                          input logic [3:0] exp_sel, input logic [31:0] exp_bw,
                          input logic [31:0] exp_load);
        logic        is_st;
        logic [31:0] res;
        int          stall_cnt;
        is_st       = (op >= 4'd6);
        wd_i        = 5'($urandom_range(1, 31));
        wreg_i      = 1'b1;
        wdata_i     = $urandom;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        exp_q.push_back(is_st ? wdata_i : exp_load);
        #1;
        chk({nm, "_c0_stall"}, 32'(stallreq_o), 32'd1);
        chk({nm, "_c0_req"}, 32'(bus_req_o), 32'd0);
        chk({nm, "_c0_align"}, 32'(align_err_o), 32'd0);
        stall_cnt = stallreq_o ? 1 : 0;
        for (int i = 1; i <= k; i++) begin
            next_cycle();
            chk({nm, "_busy_req"}, 32'(bus_req_o), 32'd1);
            if (stallreq_o) stall_cnt++;
            if (i == 1) begin
                chk({nm, "_we"}, 32'(bus_we_o), 32'(is_st));
                chk({nm, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
                chk({nm, "_sel"}, 32'(bus_sel_o), 32'(exp_sel));
                if (is_st) chk({nm, "_bwdata"}, bus_wdata_o, exp_bw);
            end
            if (i == k) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata;
            end
        end
        next_cycle();
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        #1;
        chk({nm, "_done_stall"}, 32'(stallreq_o), 32'd0);
        chk({nm, "_done_req"}, 32'(bus_req_o), 32'd0);
        chk({nm, "_stall_len"}, 32'(stall_cnt), 32'(k + 1));
        chk({nm, "_wd"}, 32'(wd_o), 32'(wd_i));
        chk({nm, "_wreg"}, 32'(wreg_o), 32'(!is_st));
        res = exp_q.pop_front();
        chk({nm, "_wdata"}, wdata_o, res);
    endtask

    initial begin
        vecs[0] = '{4'd0,  32'h0000_0000, 5'd3,  1'b1, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{4'd0,  32'h0000_0101, 5'd7,  1'b0, 32'hCAFE_0001, 1'b0, 1'b0};
        vecs[2] = '{4'd9,  32'h0000_0100, 5'd9,  1'b1, 32'h1111_2222, 1'b1, 1'b0};
        vecs[3] = '{4'd15, 32'h0000_0103, 5'd31, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0};
        vecs[4] = '{4'd5,  32'h0000_0101, 5'd4,  1'b1, 32'h0000_5555, 1'b0, 1'b1};
        vecs[5] = '{4'd8,  32'h0000_0102, 5'd5,  1'b1, 32'h0000_6666, 1'b0, 1'b1};
        vecs[6] = '{4'd3,  32'h0000_0103, 5'd6,  1'b1, 32'h0000_7777, 1'b0, 1'b1};
        vecs[7] = '{4'd4,  32'h0000_0201, 5'd8,  1'b1, 32'h0000_8888, 1'b0, 1'b1};
        vecs[8] = '{4'd7,  32'h0000_0001, 5'd10, 1'b1, 32'h0000_9999, 1'b0, 1'b1};
        vecs[9] = '{4'd5,  32'h0000_0003, 5'd11, 1'b1, 32'h0000_AAAA, 1'b0, 1'b1};

        rst         = 1'b1;
        wd_i        = 5'd5;
        wreg_i      = 1'b1;
        wdata_i     = 32'hDEAD_BEEF;
        mem_op_i    = 4'd5;
        mem_addr_i  = 32'h0000_0101;
        mem_sdata_i = 32'h1234_5678;
        bus_rdata_i = 32'd0;
        bus_ack_i   = 1'b0;
        #3;
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_align", 32'(align_err_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus", {bus_addr_o[27:0], bus_sel_o}, 32'd0);
        chk("rst_bwdata", bus_wdata_o, 32'd0);
        mem_op_i = 4'd0;
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            mem_op_i   = vecs[i].op;
            mem_addr_i = vecs[i].addr;
            wd_i       = vecs[i].wd;
            wreg_i     = vecs[i].wreg;
            wdata_i    = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_wd", i), 32'(wd_o), 32'(vecs[i].wd));
            chk($sformatf("vec%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].exp_wreg));
            chk($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].wdata);
            chk($sformatf("vec%0d_align", i), 32'(align_err_o), 32'(vecs[i].exp_align));
            chk($sformatf("vec%0d_stall", i), 32'(stallreq_o), 32'd0);
            next_cycle();
            chk($sformatf("vec%0d_req", i), 32'(bus_req_o), 32'd0);
            chk($sformatf("vec%0d_stall2", i), 32'(stallreq_o), 32'd0);
        end

        access("lb",  4'd1, 32'h0000_0103, 32'd0, 32'h0000_00F0, 2, 4'b0001, 32'd0, 32'hFFFF_FFF0);
        next_cycle(); mem_op_i = 4'd0; next_cycle();
        access("lbu", 4'd2, 32'h0000_0103, 32'd0, 32'h0000_00F0, 2, 4'b0001, 32'd0, 32'h0000_00F0);
        next_cycle(); mem_op_i = 4'd0; next_cycle();
        access("sh",  4'd7, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 1, 4'b0011, 32'hBEEF_BEEF, 32'd0);
        next_cycle(); mem_op_i = 4'd0; next_cycle();
        access("lh",  4'd3, 32'h0000_0100, 32'd0, 32'h8001_1234, $urandom_range(1, 4), 4'b1100, 32'd0, 32'hFFFF_8001);
        next_cycle();
        access("lhu", 4'd4, 32'h0000_0102, 32'd0, 32'h1234_F00D, $urandom_range(1, 4), 4'b0011, 32'd0, 32'h0000_F00D);
        next_cycle();
        access("lb1", 4'd1, 32'h0000_0101, 32'd0, 32'h1285_3456, $urandom_range(1, 4), 4'b0100, 32'd0, 32'hFFFF_FF85);
        next_cycle();
        access("sb",  4'd6, 32'h0000_0102, 32'h1234_565A, 32'h0, $urandom_range(1, 4), 4'b0010, 32'h5A5A_5A5A, 32'd0);
        next_cycle();
        access("lw0", 4'd5, 32'h0000_0000, 32'd0, 32'hA5C3_0F69, 1, 4'b1111, 32'd0, 32'hA5C3_0F69);
        next_cycle();
        access("sw4", 4'd8, 32'h0000_0004, 32'h0BAD_F00D, 32'h0, 2, 4'b1111, 32'h0BAD_F00D, 32'd0);
        next_cycle();
        mem_op_i = 4'd0;

        mem_op_i   = 4'd5;
        mem_addr_i = 32'h0000_0010;
        next_cycle();
        chk("rstbusy_req_pre", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstbusy_req", 32'(bus_req_o), 32'd0);
        chk("rstbusy_stall", 32'(stallreq_o), 32'd0);
        chk("rstbusy_wreg", 32'(wreg_o), 32'd0);
        chk("rstbusy_wdata", wdata_o, 32'd0);
        next_cycle();
        mem_op_i  = 4'd0;
        wdata_i   = 32'h0000_0055;
        wreg_i    = 1'b1;
        rst       = 1'b0;
        bus_ack_i = 1'b1;
        #1;
        chk("postrst_wdata", wdata_o, 32'h0000_0055);
        chk("postrst_wreg", 32'(wreg_o), 32'd1);
        chk("postrst_stall", 32'(stallreq_o), 32'd0);
        next_cycle();
        chk("stray_req", 32'(bus_req_o), 32'd0);
        chk("stray_stall", 32'(stallreq_o), 32'd0);
        chk("stray_wreg", 32'(wreg_o), 32'd1);
        bus_ack_i = 1'b0;
        access("lw_after", 4'd5, 32'h0000_0020, 32'd0, 32'h7654_3210, 3, 4'b1111, 32'd0, 32'h7654_3210);
        next_cycle();
        mem_op_i = 4'd0;
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
